// File: rtl/vga_pkg.sv
// Shared VGA raster constants and types: 640x480@60 default timing, coordinate
// and colour widths used by the scan generator and its axis counters.
package vga_pkg;
    localparam int COORD_W = 11;
    localparam int COLOR_W = 3;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int axis_total(int vis, int front, int sync, int back);
        return vis + front + sync + back;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;
endpackage

// File: rtl/vga_scan_generator_if.sv
// Raster bus between the scan generator (master) and the renderer / DAC side
// (slave): scan coordinates out, combinational colour back, registered pins out.
interface vga_scan_if;
    import vga_pkg::*;
    coord_t x;
    coord_t y;
    color_t rIn, gIn, bIn;
    color_t r, g, b;
    logic   hs;
    logic   vs;
    logic   frameStart;

    modport master (output x, y, r, g, b, hs, vs, frameStart,
                    input  rIn, gIn, bIn);
    modport slave  (input  x, y, r, g, b, hs, vs, frameStart,
                    output rIn, gIn, bIn);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 when enabled and flags wrap, sync window
// and visible region for the current count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    output coord_t cnt_o,
    output logic   wrap_o,
    output logic   sync_o,
    output logic   visible_o
);
    localparam int TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam int SYNC_LO = VISIBLE + FRONT;
    localparam int SYNC_HI = SYNC_LO + SYNC;

    coord_t cnt_q, cnt_d;

    // wrap_o is qualified by en_i so it can chain straight into the next axis
    assign wrap_o    = en_i && (cnt_q == COORD_W'(TOTAL - 1));
    assign sync_o    = (cnt_q >= COORD_W'(SYNC_LO)) && (cnt_q < COORD_W'(SYNC_HI));
    assign visible_o = (cnt_q < COORD_W'(VISIBLE));
    assign cnt_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = wrap_o ? '0 : cnt_q + COORD_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vga_scan_generator.sv
// VGA raster generator: pixel-tick divider, h/v scan counters, and an output
// stage that blanks and registers colour together with hs/vs (one pixel lag).
module vga_scan_generator
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = 2,
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    vga_scan_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             pixTick;
    logic             hWrap, hSync, hVis;
    logic             vWrap, vSync, vVis;
    coord_t           hCnt, vCnt;
    color_t           r_q, g_q, b_q, r_d, g_d, b_d;
    logic             hs_q, vs_q, hs_d, vs_d;

    // With CLK_DIV=1 the compare is against 0, so divCnt stays at 0 and every clk ticks
    assign pixTick  = (divCnt_q == DIV_W'(CLK_DIV - 1));
    assign divCnt_d = pixTick ? '0 : divCnt_q + DIV_W'(1);

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk(clk), .rst(rst), .en_i(pixTick),
        .cnt_o(hCnt), .wrap_o(hWrap), .sync_o(hSync), .visible_o(hVis)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk(clk), .rst(rst), .en_i(hWrap),
        .cnt_o(vCnt), .wrap_o(vWrap), .sync_o(vSync), .visible_o(vVis)
    );

    always_comb begin
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (pixTick) begin
            r_d  = (hVis && vVis) ? bus.rIn : '0;
            g_d  = (hVis && vVis) ? bus.gIn : '0;
            b_d  = (hVis && vVis) ? bus.bIn : '0;
            hs_d = hSync ? SYNC_POL : ~SYNC_POL;
            vs_d = vSync ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt_q <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
        end else begin
            divCnt_q <= divCnt_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign bus.x          = hCnt;
    assign bus.y          = vCnt;
    assign bus.r          = r_q;
    assign bus.g          = g_q;
    assign bus.b          = b_q;
    assign bus.hs         = hs_q;
    assign bus.vs         = vs_q;
    // vWrap already implies pixTick and hCnt at its last value
    assign bus.frameStart = vWrap;
endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator on a shrunken raster; expectations come from an
// edge-count arithmetic model of the raster and a stateless renderer function.
module tb_vga_scan_generator;
    import vga_pkg::*;

    localparam int   D  = 2;
    localparam int   HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int   VV = 10, VF = 2, VS = 2, VB = 2;
    localparam logic POL = 1'b0;
    localparam int   HT = HV + HF + HS + HB;
    localparam int   VT = VV + VF + VS + VB;
    localparam int   FT = HT * VT;
    localparam int   FRAME_CLKS = FT * D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_scan_if vif();

    vga_scan_generator #(
        .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst(rst), .bus(vif)
    );

    int          mode = 0;
    int unsigned seed = 0;
    int          checks = 0;
    int          failures = 0;
    int          edges = 0;

    typedef struct {
        int         x;
        int         y;
        logic [8:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    function automatic logic [8:0] colour(int m, int x, int y, int unsigned s);
        logic [8:0] c;
        case (m)
            0:       c = 9'h1FF;
            1:       c = {x[2:0], y[2:0], ~x[2:0]};
            default: c = 9'((x * 37 + y * 101 + int'(s)) ^ (x * y * 3));
        endcase
        return c;
    endfunction

    // Renderer: pure function of the scan position
    always_comb {vif.rIn, vif.gIn, vif.bIn} = colour(mode, int'(vif.x), int'(vif.y), seed);

    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    // n clk edges after release: floor(n/D) pixel ticks done; outputs show pixel p-1
    function automatic exp_t model(int n, logic rv);
        exp_t e;
        int p, pos, pp, px, py;
        e.x = 0; e.y = 0; e.rgb = '0; e.hs = ~POL; e.vs = ~POL; e.fs = 1'b0;
        if (!rv) return e;
        p   = n / D;
        pos = p % FT;
        e.x = pos % HT;
        e.y = pos / HT;
        e.fs = ((n % D) == D - 1) && (pos == FT - 1);
        if (p > 0) begin
            pp = (p - 1) % FT;
            px = pp % HT;
            py = pp / HT;
            if (px < HV && py < VV) e.rgb = colour(mode, px, py, seed);
            e.hs = (px >= HV + HF && px < HV + HF + HS) ? POL : ~POL;
            e.vs = (py >= VV + VF && py < VV + VF + VS) ? POL : ~POL;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int hold);
        @(negedge clk);
        rst = 1'b0;
        repeat (hold) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        mode = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({vif.x, vif.y, vif.r, vif.g, vif.b, vif.hs, vif.vs, vif.frameStart} !==
                {11'd0, 11'd0, 9'd0, 1'b1, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b fs=%b want zeros hs=vs=1",
                         i, vif.x, vif.y, {vif.r, vif.g, vif.b}, vif.hs, vif.vs, vif.frameStart);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (vif.x !== 11'd0) begin
            failures++;
            $display("FAIL reset_release_clk1 got x=%0d want 0", vif.x);
        end
        step();
        checks++;
        if (vif.x !== 11'd1) begin
            failures++;
            $display("FAIL reset_release_clk2 got x=%0d want 1", vif.x);
        end
    endtask

    task automatic test_line_timing();
        int falls[$];
        int rise_at;
        logic prev;
        mode = 2;
        do_reset(3);
        prev = 1'b1;
        rise_at = -1;
        for (int i = 0; i < 4 * HT * D && falls.size() < 3; i++) begin
            step();
            if (prev === 1'b1 && vif.hs === 1'b0) begin
                falls.push_back(edges);
                checks++;
                if (vif.x !== 11'(HV + HF + 1)) begin
                    failures++;
                    $display("FAIL hs_fall_x got x=%0d want %0d", vif.x, HV + HF + 1);
                end
            end
            if (prev === 1'b0 && vif.hs === 1'b1 && falls.size() == 1 && rise_at < 0)
                rise_at = edges;
            prev = vif.hs;
        end
        checks++;
        if (falls.size() < 3) begin
            failures++;
            $display("FAIL hs_fall_count got %0d want 3 within budget", falls.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (falls[k] - falls[k-1] != HT * D) begin
                    failures++;
                    $display("FAIL hs_period got %0d want %0d", falls[k] - falls[k-1], HT * D);
                end
            end
            checks++;
            if (rise_at - falls[0] != HS * D) begin
                failures++;
                $display("FAIL hs_low_width got %0d want %0d", rise_at - falls[0], HS * D);
            end
        end
    endtask

    task automatic test_frame_timing();
        int fs_at[$];
        int vfall, vrise;
        logic prev;
        mode = 2;
        do_reset(2);
        prev = 1'b1;
        vfall = -1;
        vrise = -1;
        for (int i = 0; i < 3 * FRAME_CLKS && fs_at.size() < 2; i++) begin
            step();
            if (vif.frameStart === 1'b1) fs_at.push_back(edges);
            if (prev === 1'b1 && vif.vs === 1'b0 && vfall < 0) begin
                vfall = edges;
                checks++;
                if (vif.y !== 11'(VV + VF) || vif.x !== 11'd1) begin
                    failures++;
                    $display("FAIL vs_fall_pos got x=%0d y=%0d want x=1 y=%0d", vif.x, vif.y, VV + VF);
                end
            end
            if (prev === 1'b0 && vif.vs === 1'b1 && vfall >= 0 && vrise < 0) vrise = edges;
            prev = vif.vs;
        end
        checks++;
        if (fs_at.size() < 2) begin
            failures++;
            $display("FAIL frame_start_count got %0d want 2 within budget", fs_at.size());
        end else begin
            checks++;
            if (fs_at[0] != FRAME_CLKS - 1) begin
                failures++;
                $display("FAIL frame_start_first got %0d want %0d", fs_at[0], FRAME_CLKS - 1);
            end
            checks++;
            if (fs_at[1] - fs_at[0] != FRAME_CLKS) begin
                failures++;
                $display("FAIL frame_start_period got %0d want %0d", fs_at[1] - fs_at[0], FRAME_CLKS);
            end
        end
        checks++;
        if (vfall < 0 || vrise - vfall != VS * HT * D) begin
            failures++;
            $display("FAIL vs_low_width got %0d want %0d", vrise - vfall, VS * HT * D);
        end
    endtask

    task automatic test_blanking();
        exp_t e;
        int nonzero;
        int bad;
        mode = 0;
        do_reset(2);
        nonzero = 0;
        bad = 0;
        repeat (FRAME_CLKS) begin
            step();
            e = model(edges, rst);
            if ({vif.r, vif.g, vif.b, vif.hs, vif.vs} !== {e.rgb, e.hs, e.vs}) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL blank_pixel n=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                             edges, {vif.r, vif.g, vif.b}, vif.hs, vif.vs, e.rgb, e.hs, e.vs);
            end
            if (edges % D == 0 && edges >= D && {vif.r, vif.g, vif.b} !== 9'd0) nonzero++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL blank_pixels got %0d bad samples want 0", bad);
        end
        checks++;
        if (nonzero != HV * VV) begin
            failures++;
            $display("FAIL blank_count got %0d want %0d", nonzero, HV * VV);
        end
    endtask

    task automatic test_alignment();
        exp_t e;
        mode = 1;
        do_reset(2);
        repeat (2 * HT * D) begin
            step();
            e = model(edges, rst);
            checks++;
            if (vif.r !== e.rgb[8:6] || vif.x !== 11'(e.x)) begin
                failures++;
                $display("FAIL align_r n=%0d got r=%0d x=%0d want r=%0d x=%0d",
                         edges, vif.r, vif.x, e.rgb[8:6], e.x);
            end
            if (edges % D == 0 && e.y < VV && e.x == HV) begin
                checks++;
                if (vif.r !== 3'd7) begin
                    failures++;
                    $display("FAIL align_last_visible got r=%0d want 7", vif.r);
                end
            end
            if (edges % D == 0 && e.y < VV && e.x == HV + 1) begin
                checks++;
                if (vif.r !== 3'd0) begin
                    failures++;
                    $display("FAIL align_first_blank got r=%0d want 0", vif.r);
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        int n;
        mode = 2;
        for (int round = 0; round < 4; round++) begin
            seed = $urandom;
            do_reset($urandom_range(1, 5));
            n = $urandom_range(100, 900);
            repeat (n) begin
                step();
                e = model(edges, rst);
                checks++;
                if ({vif.x, vif.y, vif.r, vif.g, vif.b, vif.hs, vif.vs, vif.frameStart} !==
                    {11'(e.x), 11'(e.y), e.rgb, e.hs, e.vs, e.fs}) begin
                    failures++;
                    $display("FAIL random_scan n=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b fs=%b want x=%0d y=%0d rgb=%h hs=%b vs=%b fs=%b",
                             edges, vif.x, vif.y, {vif.r, vif.g, vif.b}, vif.hs, vif.vs, vif.frameStart,
                             e.x, e.y, e.rgb, e.hs, e.vs, e.fs);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int tx;
        bit hit;
        bit seen;
        mode = 2;
        seed = $urandom;
        tx = $urandom_range(1, HV - 1);
        do_reset(2);
        hit = 0;
        for (int i = 0; i < FRAME_CLKS && !hit; i++) begin
            step();
            e = model(edges, rst);
            if (e.y == VV / 2 + 1 && e.x == tx && edges % D == 0) hit = 1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_reset_reach got no hit want x=%0d y=%0d", tx, VV / 2 + 1);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({vif.x, vif.y, vif.r, vif.g, vif.b, vif.hs, vif.vs, vif.frameStart} !==
            {11'd0, 11'd0, 9'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_async got x=%0d y=%0d rgb=%h hs=%b vs=%b fs=%b want zeros hs=vs=1",
                     vif.x, vif.y, {vif.r, vif.g, vif.b}, vif.hs, vif.vs, vif.frameStart);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < FRAME_CLKS + 10 && !seen; i++) begin
            step();
            if (vif.frameStart === 1'b1) begin
                seen = 1;
                checks++;
                if (edges != FRAME_CLKS - 1 || vif.x !== 11'(HT - 1) || vif.y !== 11'(VT - 1)) begin
                    failures++;
                    $display("FAIL mid_reset_frame got n=%0d x=%0d y=%0d want n=%0d x=%0d y=%0d",
                             edges, vif.x, vif.y, FRAME_CLKS - 1, HT - 1, VT - 1);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_reset_no_frame got none want frameStart within %0d clks", FRAME_CLKS + 10);
        end
        step();
        checks++;
        if (vif.x !== 11'd0 || vif.y !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset_wrap got x=%0d y=%0d want 0 0", vif.x, vif.y);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_blanking();
        test_alignment();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
